// File: rtl/wave_seq_pkg.sv
// Shared types for the two-channel waveform trigger sequencer: channel
// state encoding (exported on state_x) and trigger-source selector.
package wave_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } wave_state_e;

    typedef enum logic [1:0] {
        SRC_IMM   = 2'd0,
        SRC_SW    = 2'd1,
        SRC_EXT   = 2'd2,
        SRC_CROSS = 2'd3
    } trig_src_e;

    function automatic logic state_is_busy(input wave_state_e st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/wave_seq_channel.sv
// One sequencer channel: IDLE -> ARMED -> (HOLDOFF) -> RUN -> DONE, counting
// sample_ticks in HOLDOFF and RUN. All outputs except busy are registered.
module wave_seq_channel
    import wave_seq_pkg::*;
#(
    parameter int RUN_LEN_W = 32,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 ext_edge,
    input  logic                 cross_trig,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 sw_trig,
    input  logic [1:0]           trig_src,
    input  logic                 auto_rearm,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic [RUN_LEN_W-1:0] run_len,
    output logic                 gen_en,
    output logic                 gen_rst,
    output logic                 busy,
    output logic                 done,
    output logic [STATE_W-1:0]   state
);

    wave_state_e          st_q;
    trig_src_e            src;
    logic                 first_armed;
    logic                 trig_hit;
    logic [HOLDOFF_W-1:0] ho_sh;
    logic [HOLDOFF_W-1:0] ho_cnt;
    logic [HOLDOFF_W-1:0] ho_last;
    logic [RUN_LEN_W-1:0] rl_sh;
    logic [RUN_LEN_W-1:0] run_cnt;
    logic [RUN_LEN_W-1:0] run_last;

    assign src   = trig_src_e'(trig_src);
    assign state = st_q;
    assign busy  = state_is_busy(st_q);

    // Last-tick compares: shadows are nonzero whenever these are used, so
    // the subtraction never underflows and counters never pass the limit.
    assign ho_last  = ho_sh - HOLDOFF_W'(1);
    assign run_last = rl_sh - RUN_LEN_W'(1);

    always_comb begin
        trig_hit = 1'b0;
        case (src)
            SRC_IMM:   trig_hit = first_armed;
            SRC_SW:    trig_hit = sw_trig;
            SRC_EXT:   trig_hit = ext_edge;
            SRC_CROSS: trig_hit = cross_trig;
            default:   trig_hit = 1'b0;
        endcase
    end

    // Trigger source only selects acceptance; after acceptance only the
    // holdoff and run-length shadows steer the channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            first_armed <= 1'b0;
            ho_sh       <= '0;
            ho_cnt      <= '0;
            rl_sh       <= '0;
            run_cnt     <= '0;
            gen_en      <= 1'b0;
            gen_rst     <= 1'b0;
            done        <= 1'b0;
        end else begin
            gen_rst     <= 1'b0;
            done        <= 1'b0;
            first_armed <= 1'b0;
            if (abort) begin
                st_q    <= ST_IDLE;
                ho_cnt  <= '0;
                run_cnt <= '0;
                gen_en  <= 1'b0;
                gen_rst <= 1'b1;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        if (arm) begin
                            st_q        <= ST_ARMED;
                            first_armed <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_hit) begin
                            gen_rst <= 1'b1;
                            ho_sh   <= holdoff;
                            rl_sh   <= run_len;
                            ho_cnt  <= '0;
                            run_cnt <= '0;
                            if (holdoff == '0) begin
                                st_q   <= ST_RUN;
                                gen_en <= 1'b1;
                            end else begin
                                st_q <= ST_HOLDOFF;
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (sample_tick) begin
                            if (ho_cnt == ho_last) begin
                                st_q   <= ST_RUN;
                                gen_en <= 1'b1;
                                ho_cnt <= '0;
                            end else begin
                                ho_cnt <= ho_cnt + HOLDOFF_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        // run length zero means continuous until abort
                        if (sample_tick && (rl_sh != '0)) begin
                            if (run_cnt == run_last) begin
                                st_q    <= ST_DONE;
                                gen_en  <= 1'b0;
                                done    <= 1'b1;
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + RUN_LEN_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (auto_rearm) begin
                            st_q        <= ST_ARMED;
                            first_armed <= 1'b1;
                        end else begin
                            st_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        st_q   <= ST_IDLE;
                        gen_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/wave_trigger_sequencer.sv
// Two-channel waveform trigger sequencer: ext_trig synchronizer/edge detect
// shared by both channels. Define WAVE_SEQ_CROSS_TRIG_EN for done-to-trigger cross wiring.
module wave_trigger_sequencer
    import wave_seq_pkg::*;
#(
    parameter int RUN_LEN_W = 32,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 ext_trig,
    input  logic                 arm_a,
    input  logic                 abort_a,
    input  logic                 sw_trig_a,
    input  logic [1:0]           trig_src_a,
    input  logic                 auto_rearm_a,
    input  logic [HOLDOFF_W-1:0] holdoff_a,
    input  logic [RUN_LEN_W-1:0] run_len_a,
    input  logic                 arm_b,
    input  logic                 abort_b,
    input  logic                 sw_trig_b,
    input  logic [1:0]           trig_src_b,
    input  logic                 auto_rearm_b,
    input  logic [HOLDOFF_W-1:0] holdoff_b,
    input  logic [RUN_LEN_W-1:0] run_len_b,
    output logic                 gen_en_a,
    output logic                 gen_rst_a,
    output logic                 busy_a,
    output logic                 done_a,
    output logic [2:0]           state_a,
    output logic                 gen_en_b,
    output logic                 gen_rst_b,
    output logic                 busy_b,
    output logic                 done_b,
    output logic [2:0]           state_b
);

    logic [2:0] ext_sync;
    logic       ext_edge;
    logic       cross_a;
    logic       cross_b;

    // Two synchronizer flops plus one history flop; the edge is seen two
    // clocks after ext_trig is captured and accepted on the third edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync <= '0;
        end else begin
            ext_sync <= {ext_sync[1:0], ext_trig};
        end
    end

    assign ext_edge = ext_sync[1] & ~ext_sync[2];

`ifdef WAVE_SEQ_CROSS_TRIG_EN
    assign cross_a = done_b;
    assign cross_b = done_a;
`else
    // Without cross wiring, source 3 falls back to the software trigger.
    assign cross_a = sw_trig_a;
    assign cross_b = sw_trig_b;
`endif

    wave_seq_channel #(
        .RUN_LEN_W (RUN_LEN_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) u_chan_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ext_edge    (ext_edge),
        .cross_trig  (cross_a),
        .arm         (arm_a),
        .abort       (abort_a),
        .sw_trig     (sw_trig_a),
        .trig_src    (trig_src_a),
        .auto_rearm  (auto_rearm_a),
        .holdoff     (holdoff_a),
        .run_len     (run_len_a),
        .gen_en      (gen_en_a),
        .gen_rst     (gen_rst_a),
        .busy        (busy_a),
        .done        (done_a),
        .state       (state_a)
    );

    wave_seq_channel #(
        .RUN_LEN_W (RUN_LEN_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) u_chan_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ext_edge    (ext_edge),
        .cross_trig  (cross_b),
        .arm         (arm_b),
        .abort       (abort_b),
        .sw_trig     (sw_trig_b),
        .trig_src    (trig_src_b),
        .auto_rearm  (auto_rearm_b),
        .holdoff     (holdoff_b),
        .run_len     (run_len_b),
        .gen_en      (gen_en_b),
        .gen_rst     (gen_rst_b),
        .busy        (busy_b),
        .done        (done_b),
        .state       (state_b)
    );

endmodule

// File: tb/tb_wave_trigger_sequencer.sv
// Bench for wave_trigger_sequencer: directed table, hand-written corner
// sequences, and randomized two-channel trials against a timeline model.
module tb_wave_trigger_sequencer;
    import wave_seq_pkg::*;

    localparam int TAB_LEN = 30;
    localparam int TRIAL   = 48;
    localparam int N_RAND  = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick, ext_trig;
    logic        arm_a, abort_a, sw_trig_a, auto_rearm_a;
    logic        arm_b, abort_b, sw_trig_b, auto_rearm_b;
    logic [1:0]  trig_src_a, trig_src_b;
    logic [15:0] holdoff_a, holdoff_b;
    logic [31:0] run_len_a, run_len_b;
    logic        gen_en_a, gen_rst_a, busy_a, done_a;
    logic        gen_en_b, gen_rst_b, busy_b, done_b;
    logic [2:0]  state_a, state_b;

    int vec_cnt = 0;
    int mis_cnt = 0;

    always #5 clk = ~clk;

    wave_trigger_sequencer dut (
        .clk (clk), .rst_n (rst_n), .sample_tick (sample_tick), .ext_trig (ext_trig),
        .arm_a (arm_a), .abort_a (abort_a), .sw_trig_a (sw_trig_a),
        .trig_src_a (trig_src_a), .auto_rearm_a (auto_rearm_a),
        .holdoff_a (holdoff_a), .run_len_a (run_len_a),
        .arm_b (arm_b), .abort_b (abort_b), .sw_trig_b (sw_trig_b),
        .trig_src_b (trig_src_b), .auto_rearm_b (auto_rearm_b),
        .holdoff_b (holdoff_b), .run_len_b (run_len_b),
        .gen_en_a (gen_en_a), .gen_rst_a (gen_rst_a), .busy_a (busy_a),
        .done_a (done_a), .state_a (state_a),
        .gen_en_b (gen_en_b), .gen_rst_b (gen_rst_b), .busy_b (busy_b),
        .done_b (done_b), .state_b (state_b)
    );

    typedef struct {
        int          src;
        int          holdoff;
        int          run_len;
        int          ar;
        int          trig_at;
        int          tick_per;
        int          rst_at;
        int          en_first;
        int          en_cnt;
        int          done_at;
        wave_state_e final_st;
    } vec_t;

    vec_t tab[5];

    // random-trial timeline: trigger cycle, run start, last run cycle
    int  m_s[2], m_r[2], m_e[2], m_ar[2];
    bit  tick_tab[TRIAL];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        arm_a = 0; abort_a = 0; sw_trig_a = 0;
        arm_b = 0; abort_b = 0; sw_trig_b = 0;
        sample_tick = 0;
    endtask

    task automatic settle();
        abort_a = 1; abort_b = 1;
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    function automatic int nth_tick(input int from, input int n);
        int seen = 0;
        for (int c = from; c < TRIAL; c++) begin
            if (tick_tab[c]) begin
                seen++;
                if (seen == n) return c;
            end
        end
        return 10000;
    endfunction

    function automatic wave_state_e exp_st(input int ch, input int c);
        if (c < 1) return ST_IDLE;
        if (c <= m_s[ch]) return ST_ARMED;
        if (c < m_r[ch]) return ST_HOLDOFF;
        if (c <= m_e[ch]) return ST_RUN;
        if (c == m_e[ch] + 1) return ST_DONE;
        return (m_ar[ch] != 0) ? ST_ARMED : ST_IDLE;
    endfunction

    task automatic check_ch(input int ch, input int c, input logic [2:0] st,
                            input logic en, input logic rst, input logic dn, input logic bsy);
        wave_state_e es;
        es = exp_st(ch, c);
        check(ch == 0 ? "rnd state_a" : "rnd state_b", 32'(st), 32'(es));
        check(ch == 0 ? "rnd gen_en_a" : "rnd gen_en_b", 32'(en), 32'(es == ST_RUN));
        check(ch == 0 ? "rnd gen_rst_a" : "rnd gen_rst_b", 32'(rst), 32'(c == m_s[ch] + 1));
        check(ch == 0 ? "rnd done_a" : "rnd done_b", 32'(dn), 32'(es == ST_DONE));
        check(ch == 0 ? "rnd busy_a" : "rnd busy_b", 32'(bsy), 32'(es != ST_IDLE));
    endtask

    task automatic run_entry(input int idx, input vec_t v);
        int rst_at = -1, en_first = -1, en_cnt = 0, done_at = -1;
        int rst_cnt = 0, done_cnt = 0;
        logic [2:0] st = '0;
        trig_src_a   = 2'(v.src);
        holdoff_a    = 16'(v.holdoff);
        run_len_a    = 32'(v.run_len);
        auto_rearm_a = 1'(v.ar);
        for (int c = 0; c < TAB_LEN; c++) begin
            arm_a       = (c == 0);
            sample_tick = ((c % v.tick_per) == v.tick_per - 1);
            if (v.src == 1) sw_trig_a = (c == v.trig_at);
            if (v.src == 2 && c == v.trig_at) ext_trig = 1;
            @(negedge clk);
            if (gen_rst_a) begin rst_cnt++; if (rst_at < 0) rst_at = c; end
            if (gen_en_a) begin en_cnt++; if (en_first < 0) en_first = c; end
            if (done_a) begin done_cnt++; if (done_at < 0) done_at = c; end
            st = state_a;
            next_cycle();
        end
        ext_trig = 0;
        check($sformatf("tab%0d rst_at", idx), 32'(rst_at), 32'(v.rst_at));
        check($sformatf("tab%0d rst_cnt", idx), 32'(rst_cnt), 32'd1);
        check($sformatf("tab%0d en_first", idx), 32'(en_first), 32'(v.en_first));
        check($sformatf("tab%0d en_cnt", idx), 32'(en_cnt), 32'(v.en_cnt));
        check($sformatf("tab%0d done_at", idx), 32'(done_at), 32'(v.done_at));
        check($sformatf("tab%0d done_cnt", idx), 32'(done_cnt), 32'd1);
        check($sformatf("tab%0d final_st", idx), 32'(st), 32'(v.final_st));
        settle();
    endtask

    task automatic run_random();
        int r_ho, r_rl, r_ar;
        for (int c = 0; c < TRIAL; c++) tick_tab[c] = (c % 4 == 3) || ($urandom_range(0, 2) == 0);
        for (int ch = 0; ch < 2; ch++) begin
            m_s[ch]  = $urandom_range(1, 5);
            r_ho     = $urandom_range(0, 3);
            r_rl     = $urandom_range(1, 4);
            r_ar     = $urandom_range(0, 1);
            m_ar[ch] = r_ar;
            m_r[ch]  = (r_ho == 0) ? m_s[ch] + 1 : nth_tick(m_s[ch] + 1, r_ho) + 1;
            m_e[ch]  = nth_tick(m_r[ch], r_rl);
            if (ch == 0) begin
                holdoff_a = 16'(r_ho); run_len_a = 32'(r_rl); auto_rearm_a = 1'(r_ar);
            end else begin
                holdoff_b = 16'(r_ho); run_len_b = 32'(r_rl); auto_rearm_b = 1'(r_ar);
            end
        end
        trig_src_a = 2'd1;
        trig_src_b = 2'd1;
        for (int c = 0; c < TRIAL; c++) begin
            sample_tick = tick_tab[c];
            arm_a = (c == 0) || (c > m_s[0] && c <= m_e[0] && $urandom_range(0, 3) == 0);
            arm_b = (c == 0) || (c > m_s[1] && c <= m_e[1] && $urandom_range(0, 3) == 0);
            sw_trig_a = (c == m_s[0]) || (c == 0 && $urandom_range(0, 1) == 1) ||
                        (c > m_s[0] && c <= m_e[0] && $urandom_range(0, 3) == 0);
            sw_trig_b = (c == m_s[1]) || (c == 0 && $urandom_range(0, 1) == 1) ||
                        (c > m_s[1] && c <= m_e[1] && $urandom_range(0, 3) == 0);
            if (c > m_s[0]) begin holdoff_a = 16'($urandom); run_len_a = 32'($urandom_range(0, 7)); end
            if (c > m_s[1]) begin holdoff_b = 16'($urandom); run_len_b = 32'($urandom_range(0, 7)); end
            @(negedge clk);
            check_ch(0, c, state_a, gen_en_a, gen_rst_a, done_a, busy_a);
            check_ch(1, c, state_b, gen_en_b, gen_rst_b, done_b, busy_b);
            next_cycle();
        end
        settle();
    endtask

    initial begin
        int cnt, first_a, first_b;
        tab[0] = '{0, 0, 4, 0, -1, 1, 2, 2, 4, 6, ST_IDLE};
        tab[1] = '{1, 3, 2, 1, 3, 2, 4, 10, 4, 14, ST_ARMED};
        tab[2] = '{1, 1, 1, 0, 2, 3, 3, 6, 3, 9, ST_IDLE};
        tab[3] = '{1, 0, 3, 0, 1, 1, 2, 2, 3, 5, ST_IDLE};
        tab[4] = '{2, 0, 2, 0, 2, 1, 5, 5, 2, 7, ST_IDLE};

        rst_n = 0; ext_trig = 0; sample_tick = 0;
        arm_a = 0; abort_a = 0; sw_trig_a = 0; trig_src_a = 0; auto_rearm_a = 0;
        holdoff_a = 0; run_len_a = 0;
        arm_b = 0; abort_b = 0; sw_trig_b = 0; trig_src_b = 0; auto_rearm_b = 0;
        holdoff_b = 0; run_len_b = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("reset state_a", 32'(state_a), 32'(ST_IDLE));
        check("reset state_b", 32'(state_b), 32'(ST_IDLE));
        check("reset outs_a", {28'd0, gen_en_a, gen_rst_a, busy_a, done_a}, 32'd0);
        check("reset outs_b", {28'd0, gen_en_b, gen_rst_b, busy_b, done_b}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        next_cycle();

        for (int i = 0; i < 5; i++) run_entry(i, tab[i]);

        // triggers while IDLE are ignored; a held-high level is not an edge
        trig_src_a = 2'd2;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) ext_trig = 1;
            if (c == 2) sw_trig_a = 1;
            @(negedge clk);
            if (gen_rst_a) cnt++;
            next_cycle();
        end
        check("idle trig gen_rst_a", 32'(cnt), 32'd0);
        check("idle trig state_a", 32'(state_a), 32'(ST_IDLE));
        arm_a = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (gen_rst_a) cnt++;
            next_cycle();
        end
        check("level no trig gen_rst_a", 32'(cnt), 32'd0);
        check("level no trig state_a", 32'(state_a), 32'(ST_ARMED));
        ext_trig = 0;
        settle();

        // continuous run on B, aborted after 100 ticks
        trig_src_b = 2'd1; holdoff_b = 0; run_len_b = 0; auto_rearm_b = 0;
        cnt = 0; first_b = 0;
        for (int c = 0; c <= 102; c++) begin
            arm_b = (c == 0);
            sw_trig_b = (c == 1);
            sample_tick = (c >= 2);
            abort_b = (c == 102);
            @(negedge clk);
            if (gen_en_b) cnt++;
            if (done_b) first_b++;
            next_cycle();
        end
        @(negedge clk);
        check("cont en_b cycles", 32'(cnt), 32'd101);
        check("cont abort gen_en_b", 32'(gen_en_b), 32'd0);
        check("cont abort gen_rst_b", 32'(gen_rst_b), 32'd1);
        check("cont abort state_b", 32'(state_b), 32'(ST_IDLE));
        check("cont no done_b", 32'(first_b + int'(done_b)), 32'd0);
        next_cycle();
        settle();

        // cross trigger: B (src 3) watching A's done
        trig_src_a = 2'd1; holdoff_a = 0; run_len_a = 1; auto_rearm_a = 0;
        trig_src_b = 2'd3; holdoff_b = 0; run_len_b = 0;
        first_a = -1; first_b = -1;
        for (int c = 0; c < 9; c++) begin
            arm_a = (c == 0); arm_b = (c == 0);
            sw_trig_a = (c == 1);
            sample_tick = (c == 2);
            @(negedge clk);
            if (done_a && first_a < 0) first_a = c;
            if (gen_rst_b && first_b < 0) first_b = c;
            next_cycle();
        end
        check("cross done_a at", 32'(first_a), 32'd3);
`ifdef WAVE_SEQ_CROSS_TRIG_EN
        check("cross gen_rst_b at", 32'(first_b), 32'd4);
        check("cross state_b", 32'(state_b), 32'(ST_RUN));
`else
        check("nocross gen_rst_b", 32'(first_b), 32'hFFFFFFFF);
        check("nocross state_b", 32'(state_b), 32'(ST_ARMED));
        sw_trig_b = 1;
        next_cycle();
        @(negedge clk);
        check("nocross sw gen_rst_b", 32'(gen_rst_b), 32'd1);
        check("nocross sw state_b", 32'(state_b), 32'(ST_RUN));
`endif
        settle();

        // arm and abort in the same clock
        arm_a = 1; abort_a = 1;
        next_cycle();
        @(negedge clk);
        check("arm+abort state_a", 32'(state_a), 32'(ST_IDLE));
        check("arm+abort outs_a", {29'd0, gen_en_a, busy_a, done_a}, 32'd0);
        check("arm+abort gen_rst_a", 32'(gen_rst_a), 32'd1);
        next_cycle();
        @(negedge clk);
        check("arm+abort gen_rst_a end", 32'(gen_rst_a), 32'd0);

        // abort beats trigger
        trig_src_a = 2'd1; holdoff_a = 0;
        arm_a = 1;
        next_cycle();
        sw_trig_a = 1; abort_a = 1;
        next_cycle();
        @(negedge clk);
        check("abort vs trig state_a", 32'(state_a), 32'(ST_IDLE));
        check("abort vs trig gen_en_a", 32'(gen_en_a), 32'd0);
        settle();

        // maximum holdoff does not reach RUN early
        trig_src_a = 2'd1; holdoff_a = 16'hFFFF; run_len_a = 1;
        for (int c = 0; c < 42; c++) begin
            arm_a = (c == 0);
            sw_trig_a = (c == 1);
            sample_tick = 1;
            @(negedge clk);
            if (c == 2) check("max ho gen_rst_a", 32'(gen_rst_a), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check("max ho state_a", 32'(state_a), 32'(ST_HOLDOFF));
        check("max ho gen_en_a", 32'(gen_en_a), 32'd0);
        settle();

        // reset mid-RUN drops everything without a clock edge
        trig_src_a = 2'd1; holdoff_a = 0; run_len_a = 0;
        arm_a = 1;
        next_cycle();
        sw_trig_a = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("pre-reset gen_en_a", 32'(gen_en_a), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("async rst gen_en_a", 32'(gen_en_a), 32'd0);
        check("async rst state_a", 32'(state_a), 32'(ST_IDLE));
        check("async rst outs_a", {29'd0, gen_rst_a, busy_a, done_a}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("in rst done_a", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        next_cycle();
        @(negedge clk);
        check("post rst state_a", 32'(state_a), 32'(ST_IDLE));
        next_cycle();

        for (int t = 0; t < N_RAND; t++) run_random();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
